// File: rtl/opcode_sequencer_pkg.sv
// Shared types for the opcode sequencer: opcode encoding, FSM states, default timeout.
package ctrl_pkg;

    typedef enum logic [2:0] {
        OP_FETCH = 3'd0,
        OP_WRITE = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_MULT  = 3'd4,
        OP_DIV   = 3'd5,
        OP_SHIFT = 3'd6,
        OP_NOP   = 3'd7
    } opcode_t;

    typedef enum logic [3:0] {
        IDLE, DECODE, MEM_RD, MEM_WR, ALU1, ALU_MC, ALU_WAIT, WB, DONE, ERR
    } seq_state_t;

    localparam int DEF_TIMEOUT_CYCLES = 16;

    function automatic logic is_wait_state(seq_state_t s);
        return (s == MEM_RD) || (s == MEM_WR) || (s == ALU_WAIT);
    endfunction

endpackage

// File: rtl/opcode_sequencer_if.sv
// Instruction handshake plus memory/ALU/register-file control bundle.
interface opcode_sequencer_if #(parameter int CNT_W = 8);

    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       instruction;
    logic             mem_read;
    logic             mem_write;
    logic             mem_ack;
    logic [2:0]       alu_op;
    logic             alu_en;
    logic             alu_start;
    logic             alu_done;
    logic             rf_we;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] retired;

    // Instruction source and datapath side
    modport master (
        output instr_valid, instruction, mem_ack, alu_done,
        input  instr_ready, mem_read, mem_write, alu_op, alu_en, alu_start,
               rf_we, done, error, retired
    );

    // Sequencer side
    modport slave (
        input  instr_valid, instruction, mem_ack, alu_done,
        output instr_ready, mem_read, mem_write, alu_op, alu_en, alu_start,
               rf_we, done, error, retired
    );

endinterface

// File: rtl/opcode_sequencer_wait_timer.sv
// Wait-state cycle counter; expired_o flags the last permitted cycle before abort.
module wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic resetN,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/opcode_sequencer.sv
// Multi-cycle opcode sequencer: one instruction at a time, Moore-decoded datapath strobes.
module opcode_sequencer
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = 8
) (
    input  logic                clock,
    input  logic                resetN,
    opcode_sequencer_if.slave   bus
);

    seq_state_t       state_q, state_d;
    opcode_t          op_q;
    logic [CNT_W-1:0] retired_q;
    logic             error_q;
    logic             accept;
    logic             tmr_clr, tmr_exp;

    assign accept = bus.instr_valid && (state_q == IDLE);

    // Counter idles at zero outside wait states, so every wait state starts from 0.
    assign tmr_clr = !is_wait_state(state_q);

    wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clock     (clock),
        .resetN    (resetN),
        .clr_i     (tmr_clr),
        .en_i      (!tmr_clr),
        .expired_o (tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.instr_valid) state_d = DECODE;
            DECODE: begin
                case (op_q)
                    OP_FETCH:                 state_d = MEM_RD;
                    OP_WRITE:                 state_d = MEM_WR;
                    OP_ADD, OP_SUB, OP_SHIFT: state_d = ALU1;
                    OP_MULT, OP_DIV:          state_d = ALU_MC;
                    default:                  state_d = DONE;
                endcase
            end
            // Ack is checked before expiry so an ack in the final cycle still completes.
            MEM_RD:   if (bus.mem_ack)  state_d = WB;
                      else if (tmr_exp) state_d = ERR;
            MEM_WR:   if (bus.mem_ack)  state_d = DONE;
                      else if (tmr_exp) state_d = ERR;
            ALU1:     state_d = WB;
            ALU_MC:   state_d = ALU_WAIT;
            ALU_WAIT: if (bus.alu_done) state_d = WB;
                      else if (tmr_exp) state_d = ERR;
            WB:       state_d = DONE;
            DONE:     state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            op_q      <= OP_FETCH;
            retired_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) op_q <= opcode_t'(bus.instruction);
            if (state_q == DONE) retired_q <= retired_q + 1'b1;
            if (accept)                error_q <= 1'b0;
            else if (state_d == ERR)   error_q <= 1'b1;
        end
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.mem_read    = (state_q == MEM_RD);
    assign bus.mem_write   = (state_q == MEM_WR);
    assign bus.alu_en      = (state_q == ALU1);
    assign bus.alu_start   = (state_q == ALU_MC);
    assign bus.alu_op      = (state_q == ALU1 || state_q == ALU_MC || state_q == ALU_WAIT)
                             ? op_q : 3'd0;
    assign bus.rf_we       = (state_q == WB);
    assign bus.done        = (state_q == DONE);
    assign bus.error       = error_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_opcode_sequencer.sv
// Bench for opcode_sequencer: vector table through a scoreboard, plus reset and wrap sequences.
module tb_opcode_sequencer;

    logic clock = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    opcode_sequencer_if #(.CNT_W(8)) bus ();

    opcode_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    // ack_k: response in the k-th wait-state cycle (0 = never). lat/erc: cycle index
    // from n (DECODE cycle) of done / first error, -1 = absent.
    typedef struct {
        logic [2:0] op;
        int ack_k;
        int lat, erc, rd, wr, en, st, we, busy, errf;
    } vec_t;

    typedef struct {
        int lat, erc, rd, wr, en, st, we, busy, errf, nd;
        logic [7:0] ret;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input int ack_k, input int lat,
                                input int erc, input int rd, input int wr, input int en,
                                input int st, input int we, input int busy, input int errf);
        vec_t v;
        v.op = op; v.ack_k = ack_k; v.lat = lat; v.erc = erc; v.rd = rd; v.wr = wr;
        v.en = en; v.st = st; v.we = we; v.busy = busy; v.errf = errf;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e, a;
        int guard, wc, amis;
        logic [7:0] r0;
        logic waiting, resp;
        guard = 0;
        @(negedge clock);
        while (!bus.instr_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        chk("ready_before_issue", int'(bus.instr_ready), 1);
        r0 = bus.retired;
        e.lat = v.lat; e.erc = v.erc; e.rd = v.rd; e.wr = v.wr; e.en = v.en;
        e.st = v.st; e.we = v.we; e.busy = v.busy; e.errf = v.errf;
        e.nd = (v.lat >= 0) ? 1 : 0;
        e.ret = (v.lat >= 0) ? r0 + 8'd1 : r0;
        sb.push_back(e);
        bus.instruction = v.op;
        bus.instr_valid = 1'b1;
        @(negedge clock);
        bus.instr_valid = 1'b0;
        bus.instruction = 3'd0;
        a.lat = -1; a.erc = -1; a.rd = 0; a.wr = 0; a.en = 0; a.st = 0; a.we = 0;
        a.busy = 0; a.nd = 0; wc = 0; amis = 0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0 && bus.instr_ready) break;
            if (!bus.instr_ready) a.busy++;
            if (bus.done) begin a.lat = c; a.nd++; end
            if (bus.error && a.erc < 0) a.erc = c;
            a.rd += int'(bus.mem_read);
            a.wr += int'(bus.mem_write);
            a.en += int'(bus.alu_en);
            a.st += int'(bus.alu_start);
            a.we += int'(bus.rf_we);
            if ((bus.alu_en || bus.alu_start) && bus.alu_op != v.op) amis++;
            if (!bus.alu_en && !bus.alu_start && bus.alu_op != 3'd0 && bus.alu_op != v.op) amis++;
            waiting = bus.mem_read || bus.mem_write ||
                      (bus.alu_op != 3'd0 && !bus.alu_en && !bus.alu_start);
            if (waiting) wc++;
            resp = waiting && (wc == v.ack_k);
            bus.mem_ack  = resp && (bus.mem_read || bus.mem_write);
            bus.alu_done = resp && !(bus.mem_read || bus.mem_write);
            @(negedge clock);
        end
        bus.mem_ack = 1'b0;
        bus.alu_done = 1'b0;
        a.errf = int'(bus.error);
        e = sb.pop_front();
        chk("done_cycle", a.lat, e.lat);
        chk("done_count", a.nd, e.nd);
        chk("error_cycle", a.erc, e.erc);
        chk("error_sticky", a.errf, e.errf);
        chk("mem_read_cycles", a.rd, e.rd);
        chk("mem_write_cycles", a.wr, e.wr);
        chk("alu_en_cycles", a.en, e.en);
        chk("alu_start_cycles", a.st, e.st);
        chk("rf_we_cycles", a.we, e.we);
        chk("busy_cycles", a.busy, e.busy);
        chk("alu_op_wrong", amis, 0);
        chk("retired", int'(bus.retired), int'(e.ret));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(bus.instr_ready), 1);
        chk({tag, "_strobes"}, int'({bus.mem_read, bus.mem_write, bus.alu_en,
                                     bus.alu_start, bus.rf_we, bus.done, bus.error}), 0);
        chk({tag, "_alu_op"}, int'(bus.alu_op), 0);
        chk({tag, "_retired"}, int'(bus.retired), 0);
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instruction = 3'd0;
        bus.mem_ack     = 1'b0;
        bus.alu_done    = 1'b0;

        //              op    ack lat erc  rd  wr en st we busy errf
        vecs[0]  = mk(3'd7,  0,  1, -1,  0,  0, 0, 0, 0,  2, 0); // NOP
        vecs[1]  = mk(3'd2,  0,  3, -1,  0,  0, 1, 0, 1,  4, 0); // ADD
        vecs[2]  = mk(3'd3,  0,  3, -1,  0,  0, 1, 0, 1,  4, 0); // SUB
        vecs[3]  = mk(3'd6,  0,  3, -1,  0,  0, 1, 0, 1,  4, 0); // SHIFT
        vecs[4]  = mk(3'd0,  3,  5, -1,  3,  0, 0, 0, 1,  6, 0); // FETCH ack 3rd
        vecs[5]  = mk(3'd0,  1,  3, -1,  1,  0, 0, 0, 1,  4, 0); // FETCH ack 1st
        vecs[6]  = mk(3'd5,  0, -1, 18,  0,  0, 0, 1, 0, 19, 1); // DIV timeout
        vecs[7]  = mk(3'd7,  0,  1, -1,  0,  0, 0, 0, 0,  2, 0); // NOP clears error
        vecs[8]  = mk(3'd1, 16, 17, -1,  0, 16, 0, 0, 0, 18, 0); // WRITE ack 16th
        vecs[9]  = mk(3'd4,  2,  5, -1,  0,  0, 0, 1, 1,  6, 0); // MULT
        vecs[10] = mk(3'd0,  0, -1, 17, 16,  0, 0, 0, 0, 18, 1); // FETCH timeout
        vecs[11] = mk(3'd1,  0, -1, 17,  0, 16, 0, 0, 0, 18, 1); // WRITE timeout
        vecs[12] = mk(3'd5,  1,  4, -1,  0,  0, 0, 1, 1,  5, 0); // DIV ack 1st

        #12;
        chk_reset_outputs("reset_hold");
        @(negedge clock);
        resetN = 1'b1;

        // Stray responses while idle must not disturb anything
        bus.mem_ack = 1'b1;
        bus.alu_done = 1'b1;
        @(negedge clock);
        bus.mem_ack = 1'b0;
        bus.alu_done = 1'b0;
        chk("stray_ready", int'(bus.instr_ready), 1);
        chk("stray_retired", int'(bus.retired), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset in the middle of MULT's ALU_WAIT
        @(negedge clock);
        bus.instruction = 3'd4;
        bus.instr_valid = 1'b1;
        @(negedge clock);
        bus.instr_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("mid_mult_alu_op", int'(bus.alu_op), 4);
        chk("mid_mult_ready", int'(bus.instr_ready), 0);
        #2 resetN = 1'b0;
        #1 chk_reset_outputs("mid_reset");
        @(negedge clock);
        resetN = 1'b1;

        // 256 NOPs: retired walks to 255 and wraps to 0
        for (int i = 0; i < 256; i++) begin
            run_vec(vecs[0]);
            if (i == 254) chk("retired_255", int'(bus.retired), 255);
        end
        chk("retired_wrap", int'(bus.retired), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
